// File: rtl/gate_accumulator_pkg.sv
// ============================================================================
// Module : gate_accumulator_pkg
// Brief  : Shared fixed-point defaults and FSM encodings for the gate accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gate_accumulator_pkg;

    localparam int DEFAULT_WIDTH     = 11;
    localparam int DEFAULT_COUNT     = 16;
    localparam int DEFAULT_ACC_WIDTH = 15;

    typedef logic [0:0] state_t;

    localparam state_t ST_ACCUM = 1'b0;
    localparam state_t ST_DONE  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/nbit_carrylookahead.sv
// ============================================================================
// Module : nbit_carrylookahead
// Brief  : Parameterised adder with fully flattened carry-lookahead carries.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nbit_carrylookahead #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is the OR of every generate term propagated up to it, so
    // no carry depends on another carry.
    always_comb begin
        logic v_run;
        logic v_carry;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            v_carry = w_g[i];
            v_run   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                v_carry = v_carry | (v_run & w_g[j]);
                v_run   = v_run & w_p[j];
            end
            v_carry    = v_carry | (v_run & cin);
            w_c[i + 1] = v_carry;
        end
    end

    generate
        for (genvar k = 0; k < WIDTH; k++) begin : g_sum_bit
            assign sum[k] = w_p[k] ^ w_c[k];
        end
    endgenerate

    assign cout = w_c[WIDTH];

endmodule

`default_nettype wire

// File: rtl/gate_accumulator.sv
// ============================================================================
// Module : gate_accumulator
// Brief  : Signed accumulator of COUNT streamed terms with saturated result,
//          valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_accumulator
    import gate_accumulator_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int COUNT     = DEFAULT_COUNT,
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int CNT_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1;

    localparam logic [CNT_WIDTH-1:0] c_last    = CNT_WIDTH'(COUNT - 1);
    localparam logic [WIDTH-1:0]     c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [ACC_WIDTH-1:0]   w_term;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic                   w_carry_unused;
    logic                   w_take;
    logic                   w_last;
    logic [ACC_WIDTH-WIDTH:0] w_hi;
    logic                   w_ovf;
    logic [WIDTH-1:0]       w_sat_data;

    assign w_term = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};

    nbit_carrylookahead #(
        .WIDTH (ACC_WIDTH)
    ) u_cla (
        .a    (r_acc),
        .b    (w_term),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_carry_unused)
    );

    // A clear in the same cycle wins over the term, which is dropped.
    assign w_take = in_valid && (r_state == ST_ACCUM) && !clear;
    assign w_last = (r_cnt == c_last);

    // The sum fits in WIDTH bits only when all bits from the result sign up are equal.
    assign w_hi       = w_sum[ACC_WIDTH-1:WIDTH-1];
    assign w_ovf      = !((&w_hi) || !(|w_hi));
    assign w_sat_data = !w_ovf ? w_sum[WIDTH-1:0]
                      : (w_sum[ACC_WIDTH-1] ? c_sat_min : c_sat_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_take && w_last) w_state_next = ST_DONE;
            ST_DONE:  if (out_ready)        w_state_next = ST_ACCUM;
            default:                        w_state_next = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_ACCUM);
        out_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (r_state == ST_ACCUM) begin
            if (clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_take) begin
                if (w_last) begin
                    out_data <= w_sat_data;
                    out_sat  <= w_ovf;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
